// File: rtl/gate_pkg.sv
// Shared definitions for the multi-gate pipeline and its bench.
// Holds the 3-bit operation codes and the op field width.
package gate_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT_A = 3'd6;  // b ignored
  localparam logic [OP_W-1:0] OP_BUF_A = 3'd7;  // b ignored

endpackage

// File: rtl/gate_alu.sv
// Purely combinational bitwise gate unit.
// Ports:
//   a_i, b_i : operands (WIDTH bits)
//   op_i     : operation select (gate_pkg OP_* codes, all 8 legal)
//   y_o      : bitwise result (WIDTH bits)
module gate_alu
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_AND:   y_o = a_i & b_i;
      OP_OR:    y_o = a_i | b_i;
      OP_XOR:   y_o = a_i ^ b_i;
      OP_NAND:  y_o = ~(a_i & b_i);
      OP_NOR:   y_o = ~(a_i | b_i);
      OP_XNOR:  y_o = ~(a_i ^ b_i);
      OP_NOT_A: y_o = ~a_i;
      OP_BUF_A: y_o = a_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_gate_pipe.sv
// Two-stage valid/ready pipeline around a bitwise gate unit.
// S1 registers the operand beat (a, b, op); S2 registers the gate result
// together with its OR-reduction. A saturating counter tracks output transfers.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : operand handshake (a, b, op sampled on transfer)
//   out_valid/out_ready     : result handshake (y, y_any)
//   cnt_clr                 : synchronous clear of xfer_cnt (beats a transfer)
//   xfer_cnt                : saturating count of output transfers
module multi_gate_pipe
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] xfer_cnt
);

  // Stage 1: operand registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;

  // Stage 2: result registers
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_any_q, y_any_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_y;
  logic             s2_can_load;
  logic             s1_advance;
  logic             in_xfer;
  logic             out_xfer;

  gate_alu #(
    .WIDTH (WIDTH)
  ) u_gate_alu (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .op_i (s1_op_q),
    .y_o  (alu_y)
  );

  // S2 frees up either when empty or when its beat leaves this cycle, so
  // in_ready has a combinational path from out_ready.
  assign s2_can_load = !s2_valid_q || out_ready;
  assign s1_advance  = s1_valid_q && s2_can_load;
  assign in_ready    = !s1_valid_q || s1_advance;
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      s1_a_d  = a;
      s1_b_d  = b;
      s1_op_d = op;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    y_any_d    = y_any_q;
    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_advance) begin
      y_d     = alu_y;
      y_any_d = |alu_y;
    end
  end

  // Clear has priority; otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      y_any_q    <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      y_any_q    <= y_any_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign y_any     = y_any_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_multi_gate_pipe.sv
// Bench for multi_gate_pipe: two instances (CNT_W=16 and CNT_W=4) share stimulus.
// A queue-based model tracks beats in flight and checks every cycle.
module tb_multi_gate_pipe;
  import gate_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, out_ready, cnt_clr;
  logic [W-1:0]  a, b;
  logic [2:0]    op;

  logic          in_ready, out_valid, y_any;
  logic [W-1:0]  y;
  logic [15:0]   xfer_cnt;
  logic          in_ready4, out_valid4, y_any4;
  logic [W-1:0]  y4;
  logic [3:0]    xfer_cnt4;

  multi_gate_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op(op), .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_any(y_any),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
  );

  multi_gate_pipe #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
    .op(op), .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .y_any(y_any4),
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt4)
  );

  typedef struct {
    logic [W-1:0] y;
    int           age;
  } ent_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] ey;
    logic         eany;
  } vec_t;

  ent_t         mq[$];
  int           m_cnt16, m_cnt4;
  logic [W-1:0] log_y[$];
  logic         log_any[$];
  int           n_tests = 0;
  int           n_fail = 0;

  function automatic logic [W-1:0] ref_gate(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic [2:0] rop);
    case (rop)
      OP_AND:   return ra & rb;
      OP_OR:    return ra | rb;
      OP_XOR:   return ra ^ rb;
      OP_NAND:  return ~(ra & rb);
      OP_NOR:   return ~(ra | rb);
      OP_XNOR:  return ~(ra ^ rb);
      OP_NOT_A: return ~ra;
      default:  return ra;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check all outputs against the model at the
  // falling edge, then advance the model across the rising edge.
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] iop, input logic ordy, input logic clr,
                       output logic acc);
    logic m_rdy, m_ov, ox;
    ent_t e;
    in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy; cnt_clr = clr;
    @(negedge clk);
    m_rdy = (mq.size() < 2) || ordy;
    m_ov  = (mq.size() > 0) && (mq[0].age >= 1);
    check("in_ready", in_ready, m_rdy);
    check("out_valid", out_valid, m_ov);
    check("in_ready_c4", in_ready4, m_rdy);
    check("out_valid_c4", out_valid4, m_ov);
    if (m_ov) begin
      check("y", y, mq[0].y);
      check("y_any", y_any, |mq[0].y);
      check("y_c4", y4, mq[0].y);
    end
    check("xfer_cnt", xfer_cnt, m_cnt16);
    check("xfer_cnt_c4", xfer_cnt4, m_cnt4);
    ox  = m_ov && ordy;
    acc = iv && m_rdy;
    if (ox) begin
      log_y.push_back(y);
      log_any.push_back(y_any);
    end
    foreach (mq[i]) mq[i].age++;
    if (ox) void'(mq.pop_front());
    if (acc) begin
      e.y = ref_gate(ia, ib, iop);
      e.age = 0;
      mq.push_back(e);
    end
    if (clr) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else if (ox) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 3'd0, ordy, 1'b0, acc);
  endtask

  // Reset asserted in the middle of a cycle; outputs must drop immediately.
  task automatic mid_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_y"}, y, '0);
    check({tag, "_y_any"}, y_any, 1'b0);
    check({tag, "_cnt"}, xfer_cnt, '0);
    check({tag, "_cnt_c4"}, xfer_cnt4, '0);
    mq.delete();
    m_cnt16 = 0;
    m_cnt4  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t         tv[10];
  vec_t         bp[3];
  logic         acc;
  int           idx;
  int           guard;
  logic [W-1:0] held;

  initial begin
    tv[0] = '{8'hCC, 8'hAA, OP_AND,   8'h88, 1'b1};
    tv[1] = '{8'hCC, 8'hAA, OP_OR,    8'hEE, 1'b1};
    tv[2] = '{8'hCC, 8'hAA, OP_XOR,   8'h66, 1'b1};
    tv[3] = '{8'hCC, 8'hAA, OP_NAND,  8'h77, 1'b1};
    tv[4] = '{8'hCC, 8'hAA, OP_NOR,   8'h11, 1'b1};
    tv[5] = '{8'hCC, 8'hAA, OP_XNOR,  8'h99, 1'b1};
    tv[6] = '{8'hCC, 8'hAA, OP_NOT_A, 8'h33, 1'b1};
    tv[7] = '{8'hCC, 8'hAA, OP_BUF_A, 8'hCC, 1'b1};
    tv[8] = '{8'h00, 8'h00, OP_OR,    8'h00, 1'b0};
    tv[9] = '{8'h0F, 8'h30, OP_OR,    8'h3F, 1'b1};

    bp[0] = '{8'h12, 8'h34, OP_XOR,   8'h26, 1'b1};
    bp[1] = '{8'hF0, 8'h0F, OP_OR,    8'hFF, 1'b1};
    bp[2] = '{8'h55, 8'h00, OP_NOT_A, 8'hAA, 1'b1};

    m_cnt16 = 0;
    m_cnt4  = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, '0);
    check("rst_cnt", xfer_cnt, '0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Truth table plus y_any vectors, back to back
    log_y.delete(); log_any.delete();
    for (int i = 0; i < 10; i++) cycle(1'b1, tv[i].a, tv[i].b, tv[i].op, 1'b1, 1'b0, acc);
    idle(1'b1, 2);
    check("tt_count", log_y.size(), 10);
    for (int i = 0; i < 10 && i < log_y.size(); i++) begin
      check($sformatf("tt_y[%0d]", i), log_y[i], tv[i].ey);
      check($sformatf("tt_any[%0d]", i), log_any[i], tv[i].eany);
    end

    // Backpressure: three beats offered while downstream stalls
    cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
    log_y.delete(); log_any.delete();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, bp[idx].a, bp[idx].b, bp[idx].op, 1'b0, 1'b0, acc);
      if (acc) idx++;
      if (c == 2) held = y;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_y_value", y, bp[0].ey);
    check("bp_y_held", y, held);
    guard = 0;
    while (idx < 3 && guard < 10) begin
      cycle(1'b1, bp[idx].a, bp[idx].b, bp[idx].op, 1'b1, 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    check("bp_third_accepted", idx, 3);
    idle(1'b1, 3);
    check("bp_count", log_y.size(), 3);
    for (int i = 0; i < 3 && i < log_y.size(); i++)
      check($sformatf("bp_order[%0d]", i), log_y[i], bp[i].ey);
    check("bp_xfer_cnt", xfer_cnt, 3);

    // Counter saturation and clear-over-transfer priority
    cycle(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 20; i++) cycle(1'b1, W'(i), 8'h5A, 3'(i), 1'b1, 1'b0, acc);
    idle(1'b1, 2);
    check("cnt16_20", xfer_cnt, 20);
    check("cnt4_sat", xfer_cnt4, 15);
    cycle(1'b1, 8'h81, 8'h18, OP_OR, 1'b0, 1'b0, acc);
    idle(1'b0, 1);
    check("clr_pre_valid", out_valid, 1'b1);
    cycle(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, acc);
    check("clr_wins", xfer_cnt, 0);
    check("clr_wins_c4", xfer_cnt4, 0);
    check("clr_drained", out_valid, 1'b0);

    // Reset with two beats in flight
    cycle(1'b1, 8'hA5, 8'h0F, OP_AND, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h3C, 8'hFF, OP_XOR, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h77, 8'h11, OP_NOR, 1'b0, 1'b0, acc);
    mid_reset("midrst");
    idle(1'b1, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 3'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), acc);
    end
    idle(1'b1, 3);
    check("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_gate_pipe.md
MULTI_GATE_PIPE -- requirements
Module: multi_gate_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (>=1).
REQ-002 Parameter: CNT_W, default 16, width of transfer counter (>=2).
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operand beat valid.
REQ-006 Port: in_ready  output  1  block can accept a beat.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: op  input  3  operation select, sampled with the beat.
REQ-010 Port: out_valid  output  1  result beat valid.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: y  output  WIDTH  bitwise result.
REQ-013 Port: y_any  output  1  OR-reduction of y.
REQ-014 Port: cnt_clr  input  1  synchronous clear of xfer_cnt.
REQ-015 Port: xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-016 op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A (b ignored), 7 BUF_A (b ignored); all codes legal.
REQ-017 Input transfer = in_valid && in_ready in a cycle; output transfer = out_valid && out_ready.
REQ-018 Two register stages: S1 captures a, b, op on input transfer; S2 captures computed result from S1.
REQ-019 Latency: beat accepted at edge N appears with out_valid=1 after edge N+1, with no backpressure.
REQ-020 S2 loads when S1 valid and (S2 empty or out_ready); S1 loads when S1 empty or S1 moves to S2.
REQ-021 in_ready = !s1_valid || s1_advance; it may depend combinationally on out_ready.
REQ-022 Throughput one beat per cycle while out_ready held high.
REQ-023 While out_valid && !out_ready, y and y_any hold stable; no beat is dropped, duplicated or reordered.
REQ-024 Maximum occupancy two beats; with both stages full and out_ready=0, in_ready=0.
REQ-025 y_any is registered with y, equal to |y of the presented beat.
REQ-026 xfer_cnt increments by 1 per output transfer; it saturates at all-ones, with no wrap.
REQ-027 cnt_clr=1 sets xfer_cnt to 0 at the next edge; clear wins over a simultaneous transfer.
REQ-028 in_valid with in_ready=0 has no effect; the block does not require the source to hold data.

Reset
REQ-029 rst_n=0 immediately forces S1/S2 valids to 0, y=0, y_any=0, xfer_cnt=0, out_valid=0.
REQ-030 In-flight beats are discarded on reset, and in_ready=1 in the first cycle after release.

Structure
REQ-031 Op codes (OP_AND..OP_BUF_A, 3-bit localparams) belong in shared package gate_pkg, reused by the bench.
REQ-032 One sub-module, gate_alu (purely combinational, WIDTH-parametrised, a/b/op -> y), is instantiated between S1 and S2.

Verification
REQ-033 Reset: assert rst_n=0 mid-stream -> out_valid=0, y=0x00, xfer_cnt=0 at once; in_ready=1 after release.
REQ-034 Truth table: a=0xCC, b=0xAA, op 0..7 back-to-back with out_ready=1 -> y = 0x88, 0xEE, 0x66, 0x77, 0x11, 0x99, 0x33, 0xCC in order, one per cycle, first two edges after first accept.
REQ-035 y_any: OR with a=0x00, b=0x00 -> y=0x00, y_any=0; a=0x0F, b=0x30 -> y=0x3F, y_any=1.
REQ-036 Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, y held; raise out_ready -> all 3 delivered in order, xfer_cnt=3.
REQ-037 Counter: CNT_W=4, 20 transfers -> xfer_cnt=15; cnt_clr with a concurrent transfer -> xfer_cnt=0.
